// File: rtl/pe_accum_f32.sv
// Sequencing accumulator in front of an external combinational float32 adder.
// Streams `len` operands in, folds them into a running sum, returns it over valid/ready.
module pe_accum_f32 #(
    parameter int WIDTH  = 32,
    parameter int COUNTW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [COUNTW-1:0] len,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic [WIDTH-1:0]  add_a,
    output logic [WIDTH-1:0]  add_b,
    input  logic [WIDTH-1:0]  add_sum,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [COUNTW-1:0] elem_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    opnd_q, opnd_d;
    logic [COUNTW-1:0]   remaining_q, remaining_d;
    logic [COUNTW-1:0]   elem_count_q, elem_count_d;
    logic                first_q, first_d;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        remaining_d  = remaining_q;
        elem_count_d = elem_count_q;
        first_d      = first_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d        = '0;
                    elem_count_d = '0;
                    if (len != '0) begin
                        remaining_d = len;
                        first_d     = 1'b1;
                        state_d     = ST_LOAD;
                    end else begin
                        remaining_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_LOAD: begin
                if (in_valid) begin
                    elem_count_d = elem_count_q + COUNTW'(1);
                    remaining_d  = remaining_q - COUNTW'(1);
                    // First operand seeds the sum directly instead of a 0+x adder pass.
                    if (first_q) begin
                        acc_d   = in_data;
                        first_d = 1'b0;
                        state_d = (remaining_q == COUNTW'(1)) ? ST_DONE : ST_LOAD;
                    end else begin
                        opnd_d  = in_data;
                        state_d = ST_ADD;
                    end
                end
            end

            ST_ADD: begin
                acc_d   = add_sum;
                state_d = (remaining_q == '0) ? ST_DONE : ST_LOAD;
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            opnd_q       <= '0;
            remaining_q  <= '0;
            elem_count_q <= '0;
            first_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            opnd_q       <= opnd_d;
            remaining_q  <= remaining_d;
            elem_count_q <= elem_count_d;
            first_q      <= first_d;
        end
    end

    // Handshake flags decode the state register only; no path from in_valid/out_ready.
    assign in_ready   = (state_q == ST_LOAD);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = acc_q;
    assign add_a      = acc_q;
    assign add_b      = opnd_q;
    assign elem_count = elem_count_q;

endmodule

// File: tb/tb_pe_accum_f32.sv
// Directed bench for pe_accum_f32 with a behavioural float32 adder on add_a/add_b.
module tb_pe_accum_f32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] add_a, add_b, add_sum;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [7:0]  elem_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pe_accum_f32 #(.WIDTH(32), .COUNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .elem_count(elem_count)
    );

    // Same-sign float32 add, truncating; adequate for the exact-valued vectors used here.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, e;
        logic [24:0] ma, mb, s;
        logic [31:0] t;
        int          sh;
        if (a[30:0] == 31'd0) return b;
        if (b[30:0] == 31'd0) return a;
        if (a[30:23] < b[30:23]) begin t = a; a = b; b = t; end
        ea = a[30:23]; eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        sh = int'(ea) - int'(eb);
        mb = (sh > 24) ? 25'd0 : (mb >> sh);
        s  = ma + mb;
        e  = ea;
        if (s[24]) begin s = s >> 1; e = e + 8'd1; end
        return {a[31], e, s[22:0]};
    endfunction

    assign add_sum = fadd(add_a, add_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] ops [4];
        logic [31:0] exp_sum;
        int          exp_cycles;
    } vec_t;

    vec_t vecs [7];

    // Runs one accumulation with in_valid held high; operands beyond index 3 repeat ops[3].
    task automatic run_vec(input vec_t v);
        int cyc, idx, add_cyc;
        bit hs;
        start = 1'b1; len = 8'(v.n); in_valid = 1'b1; in_data = v.ops[0];
        idx = 0; cyc = 0; add_cyc = 0;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!out_valid && cyc < 2 * v.n + 20) begin
            in_data = v.ops[(idx < 3) ? idx : 3];
            if (busy && !in_ready && !out_valid) add_cyc++;
            hs = in_ready && in_valid;
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({v.name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, " latency"}, 32'(cyc), 32'(v.exp_cycles));
        chk({v.name, " out_data"}, out_data, v.exp_sum);
        chk({v.name, " accepts"}, 32'(idx), 32'(v.n));
        chk({v.name, " elem_count"}, 32'(elem_count), 32'(v.n));
        chk({v.name, " add cycles"}, 32'(add_cyc), 32'((v.n > 0) ? v.n - 1 : 0));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({v.name, " back to idle"}, {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"basic3",  3, '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0}, 32'h40C0_0000, 6};
        vecs[1] = '{"single",  1, '{32'hC120_0000, 32'h0, 32'h0, 32'h0},                32'hC120_0000, 2};
        vecs[2] = '{"zero",    0, '{32'h3F80_0000, 32'h0, 32'h0, 32'h0},                32'h0000_0000, 1};
        vecs[3] = '{"two",     2, '{32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0},        32'h4000_0000, 4};
        vecs[4] = '{"four",    4, '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000}, 32'h4120_0000, 8};
        vecs[5] = '{"halves",  2, '{32'h3F00_0000, 32'h3FC0_0000, 32'h0, 32'h0},        32'h4000_0000, 4};
        vecs[6] = '{"max255", 255, '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}, 32'h437F_0000, 510};

        rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        #12;
        chk("reset outputs", {in_ready, out_valid, busy, elem_count, out_data, add_a, add_b} == '0 ? 32'd0 : 32'd1, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Input backpressure: gap of 5 cycles between the two operands.
        start = 1'b1; len = 8'd2;
        @(posedge clk); #1; start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1; in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp in_ready", {31'd0, in_ready}, 32'd1);
            chk("bp elem_count", 32'(elem_count), 32'd1);
        end
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("bp in add", {30'd0, in_ready, busy}, 32'd1);
        @(posedge clk); #1;
        chk("bp out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp out_data", out_data, 32'h4000_0000);

        // Output backpressure with an ignored start pulse.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin start = 1'b1; len = 8'd5; end
            else start = 1'b0;
            @(posedge clk); #1;
            chk("obp out_valid", {31'd0, out_valid}, 32'd1);
            chk("obp out_data", out_data, 32'h4000_0000);
            chk("obp elem_count", 32'(elem_count), 32'd2);
        end
        out_ready = 1'b1; start = 1'b1; len = 8'd1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("start with out_ready ignored", {30'd0, busy, in_ready}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("start next cycle accepted", {30'd0, busy, in_ready}, 32'd3);
        in_valid = 1'b1; in_data = 32'h4040_0000;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("post-obp single", out_data, 32'h4040_0000);
        out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Reset asserted mid-ADD of a 4-element run.
        start = 1'b1; len = 8'd4;
        @(posedge clk); #1; start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        @(posedge clk); #1; in_data = 32'h4000_0000;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("in ADD before reset", {30'd0, busy, in_ready}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset flags", {29'd0, in_ready, out_valid, busy}, 32'd0);
        chk("async reset out_data", out_data, 32'd0);
        chk("async reset add_a", add_a, 32'd0);
        chk("async reset add_b", add_b, 32'd0);
        chk("async reset elem_count", 32'(elem_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_vec('{"after reset", 1, '{32'h3F80_0000, 32'h0, 32'h0, 32'h0}, 32'h3F80_0000, 2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
